// File: rtl/timer_array.sv
// timer_array: multi-channel prescaled periodic/one-shot timer with sticky pending bits and masked level interrupt
module timer_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter int PRESC_W = 8,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_limit,
  input  logic               cfg_mode,
  input  logic               cfg_en,
  input  logic [NUM_CH-1:0]  int_clr,
  input  logic [NUM_CH-1:0]  int_mask,
  output logic [NUM_CH-1:0]  pending,
  output logic [CNT_W-1:0]   cnt_rd,
  output logic               timer_int
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  logic [PRESC_W-1:0] p;
  logic tick;
  logic [NUM_CH-1:0] fire;
  logic [CNT_W-1:0] cnt_a [NUM_CH];
  assign tick = p >= presc_div;
  always_ff @(posedge clk or posedge reset)
    if (reset) p <= '0;
    else p <= tick ? '0 : p + PRESC_W'(1);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_t st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, limit;
    logic mode, wr, hit;
    assign wr = cfg_we && cfg_ch == CH_W'(c);
    assign hit = st == RUN && tick && cnt == limit - CNT_W'(1);
    // a config write owns the channel for its edge, so a coincident tick is dropped
    always_comb begin
      st_n = st;
      cnt_n = cnt;
      if (wr) begin
        st_n = cfg_en && cfg_limit != '0 ? RUN : IDLE;
        cnt_n = '0;
      end else if (st == RUN && tick) begin
        st_n = hit && mode ? DONE : RUN;
        cnt_n = hit ? '0 : cnt + CNT_W'(1);
      end
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st <= IDLE;
        cnt <= '0;
        limit <= '0;
        mode <= 1'b0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
        if (wr) begin
          limit <= cfg_limit;
          mode <= cfg_mode;
        end
      end
    assign fire[c] = hit && !wr;
    assign cnt_a[c] = cnt;
  end
  // set has priority over clear so an expiry coinciding with service is kept
  always_ff @(posedge clk or posedge reset)
    if (reset) pending <= '0;
    else pending <= fire | (pending & ~int_clr);
  assign timer_int = |(pending & int_mask);
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NUM_CH; i++) cnt_rd = cfg_ch == CH_W'(i) ? cnt_a[i] : cnt_rd;
  end
endmodule
